// File: rtl/counting_sorter.sv
// counting_sorter: a parametrised counting-sort engine.
// A frame of DATA_NUM samples is counted into a histogram of 2^DATA_W bins.
// The bins are then scanned in ascending or descending order, and each sample
// is re-emitted through a ready/valid output stage that marks the last sample.
// The histogram is cleared one bin per cycle before each frame.
// Optional build macro COUNTING_SORTER_SIGNED_EN: samples are treated as two's
// complement by inverting the MSB when mapping between sample and bin index.
module counting_sorter #(
  parameter int DATA_W   = 8,
  parameter int DATA_NUM = 256,
  parameter int CNT_W    = $clog2(DATA_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              descend,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              last_out,
  output logic              busy
);

  localparam int                BINS     = 1 << DATA_W;
  localparam logic [DATA_W-1:0] BIN_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_NUM - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_NUM);

  // XOR mask that maps a sample to its bin index and back again.
`ifdef COUNTING_SORTER_SIGNED_EN
  localparam logic [DATA_W-1:0] KEY_XOR = DATA_W'(1) << (DATA_W - 1);
`else
  localparam logic [DATA_W-1:0] KEY_XOR = '0;
`endif

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_EMIT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] clr_idx_q, clr_idx_d;    // bin being zeroed in CLEAR
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;  // samples accepted this frame
  logic [CNT_W-1:0]  emit_cnt_q, emit_cnt_d;  // samples emitted this frame
  logic [DATA_W-1:0] ptr_q, ptr_d;            // scan pointer in EMIT
  logic              desc_q, desc_d;          // frame sort direction
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              last_out_q, last_out_d;

  // Histogram storage with a single write port and two combinational reads.
  logic [CNT_W-1:0]  hist_q [BINS];
  logic              hist_we;
  logic [DATA_W-1:0] hist_waddr;
  logic [CNT_W-1:0]  hist_wdata;

  logic [DATA_W-1:0] in_key;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  ptr_cnt;
  logic [DATA_W-1:0] ptr_step;
  logic              accept;
  logic              out_free;
  logic              out_fire;
  logic              emit_done;

  assign ready_in  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

  assign in_key    = data_in ^ KEY_XOR;
  assign in_cnt    = hist_q[in_key];
  assign ptr_cnt   = hist_q[ptr_q];
  assign ptr_step  = desc_q ? (ptr_q - DATA_W'(1)) : (ptr_q + DATA_W'(1));
  assign accept    = valid_in && ready_in;
  assign out_fire  = valid_out_q && ready_out;
  assign out_free  = !valid_out_q || ready_out;
  assign emit_done = (emit_cnt_q == CNT_FULL);

  // Next-state logic: clear sweep, histogram fill, and sorted scan/emit.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    fill_cnt_d  = fill_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    ptr_d       = ptr_q;
    desc_d      = desc_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    hist_we     = 1'b0;
    hist_waddr  = ptr_q;
    hist_wdata  = ptr_cnt;

    unique case (state_q)
      ST_CLEAR: begin
        hist_we    = 1'b1;
        hist_waddr = clr_idx_q;
        hist_wdata = '0;
        clr_idx_d  = clr_idx_q + DATA_W'(1);
        if (clr_idx_q == BIN_MAX) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          hist_we    = 1'b1;
          hist_waddr = in_key;
          hist_wdata = in_cnt + CNT_W'(1);
          if (fill_cnt_q == CNT_LAST) begin
            fill_cnt_d = '0;
            emit_cnt_d = '0;
            desc_d     = descend;
            ptr_d      = descend ? BIN_MAX : '0;
            state_d    = ST_EMIT;
          end else begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EMIT: begin
        if (out_fire) begin
          valid_out_d = 1'b0;
          last_out_d  = 1'b0;
        end
        if (out_fire && last_out_q) begin
          clr_idx_d = '0;
          state_d   = ST_CLEAR;
        end else if (!emit_done) begin
          if (ptr_cnt == '0) begin
            ptr_d = ptr_step;
          end else if (out_free) begin
            data_out_d  = ptr_q ^ KEY_XOR;
            valid_out_d = 1'b1;
            last_out_d  = (emit_cnt_q == CNT_LAST);
            emit_cnt_d  = emit_cnt_q + CNT_W'(1);
            hist_we     = 1'b1;
            hist_waddr  = ptr_q;
            hist_wdata  = ptr_cnt - CNT_W'(1);
            if (ptr_cnt == CNT_W'(1)) begin
              ptr_d = ptr_step;
            end
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      fill_cnt_q  <= '0;
      emit_cnt_q  <= '0;
      ptr_q       <= '0;
      desc_q      <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      fill_cnt_q  <= fill_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      ptr_q       <= ptr_d;
      desc_q      <= desc_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  // Histogram write port.
  always_ff @(posedge clk) begin
    // NOTE: the histogram has no reset; the CLEAR sweep zeroes it after every
    // reset and frame, so it can map onto RAM without a reset network.
    if (hist_we) begin
      hist_q[hist_waddr] <= hist_wdata;
    end
  end

endmodule
